// File: rtl/uart_rx_pkg.sv
// Shared UART types and constants, used by the receiver and by the UART sender.
package uart_rx_pkg;

    typedef logic [7:0] w8;
    typedef logic [7:0] r8;

    // 100 MHz system clock / 115200 baud
    localparam int UART_CLK_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter
// so idle-high lines come out of reset at their idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the async input through two flops; r_sync[1] is the safe copy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, finds the start bit by level, samples each
// bit at mid-period, emits a one-cycle rx_ready with rdata, or a one-cycle ferr when
// the stop bit is 0 (then waits for the line to go high again).
// Optional macro UART_RX_MAJORITY_EN: every sample becomes a 2-of-3 vote over the
// cycles around mid-bit; the decision lands one cycle later than the single sample.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic rxd,
    output logic rx_ready,
    output w8    rdata,
    output logic ferr,
    output logic busy
);

    localparam int CW  = $clog2(CLK_PER_BIT) + 1;
    localparam int MID = CLK_PER_BIT / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    // Vote needs the sample after mid, so the decision is taken at mid+1
    localparam int START_PT = MID + 1;
`else
    localparam int START_PT = MID;
`endif
    localparam logic [CW-1:0] START_PT_C = CW'(START_PT);
    localparam logic [CW-1:0] BIT_PT_C   = CW'(CLK_PER_BIT - 1);

    logic w_rxs;
    logic w_sample;

    uart_rx_state_t r_state, w_state_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [2:0]     r_bit, w_bit_next;
    r8              r_shift, w_shift_next;
    r8              r_rdata, w_rdata_next;
    logic           r_rx_ready, w_rx_ready_next;
    logic           r_ferr, w_ferr_next;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (rxd),
        .o_q   (w_rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synchronised samples for the 2-of-3 vote
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_rx_ready <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_rdata    <= w_rdata_next;
            r_rx_ready <= w_rx_ready_next;
            r_ferr     <= w_ferr_next;
        end
    end

    // Next-state and output decode; counter is cleared on every sample and state change
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + CW'(1);
        w_bit_next      = r_bit;
        w_shift_next    = r_shift;
        w_rdata_next    = r_rdata;
        w_rx_ready_next = 1'b0;
        w_ferr_next     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                // level, not edge: a line still low after a break restarts here
                if (!w_rxs) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == START_PT_C) begin
                    w_cnt_next = '0;
                    if (w_sample) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_bit_next   = '0;
                    end
                end
            end
            DATA: begin
                if (r_cnt == BIT_PT_C) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_sample, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                if (r_cnt == BIT_PT_C) begin
                    w_cnt_next = '0;
                    if (w_sample) begin
                        // leave at mid-stop so a back-to-back start bit is not missed
                        w_rx_ready_next = 1'b1;
                        w_rdata_next    = r_shift;
                        w_state_next    = IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                w_cnt_next = '0;
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign rx_ready = r_rx_ready;
    assign ferr     = r_ferr;
    assign rdata    = r_rdata;
    assign busy     = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver feeding the boot loader and, after boot, the CPU's input path.
- Synchronises the asynchronous serial line and detects start bits.
- Samples each bit at mid-period and presents each received byte as a one-cycle `rx_ready` pulse with `rdata` held stable.
- Flags framing errors; never emits a byte whose stop bit was 0.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 8..65535.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- rxd  input  1  asynchronous serial line, idle high
- rx_ready  output  1  one-cycle pulse: valid byte on `rdata`
- rdata  output  8  (w8) last valid byte; changes only in the cycle `rx_ready` rises
- ferr  output  1  one-cycle pulse: stop bit sampled as 0
- busy  output  1  high while a frame is being received (states START, DATA, STOP)

Behaviour:
- Reset values:
  - `rx_ready`=0, `ferr`=0, `rdata`=8'h00, `busy`=0.
  - Synchroniser flops=1, state=IDLE, bit counter=0, cycle counter=0.
- Synchroniser: `rxd` passes through 2 flops giving `rxs`. All logic uses `rxs` only.
- Cycle counter:
  - Width $clog2(CLK_PER_BIT)+1.
  - Cleared on every state change.
  - Cleared after each bit sample.
- IDLE:
  - `rxs`==0 → START, counter=0.
  - A low level (not only an edge) starts a frame, so a line already low after BREAK is handled.
- START:
  - At counter==CLK_PER_BIT/2−1, sample the start bit.
  - Sample 1 → IDLE (glitch rejected, no outputs).
  - Sample 0 → DATA, bit index=0, counter=0.
- DATA:
  - Every CLK_PER_BIT cycles, sample one bit into a shift register, LSB first (new bit enters at [7], shift right).
  - After bit index 7 is sampled → STOP.
- STOP, sampled CLK_PER_BIT cycles after the last data bit:
  - Sample 1 → next cycle `rx_ready`=1, `rdata`=shift register; state → IDLE the same cycle as the sample.
  - Sample 0 → next cycle `ferr`=1, `rdata` unchanged; state → WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`==1, then IDLE. A break therefore produces exactly one `ferr` and no bytes.
- Latency:
  - `rx_ready` rises 2 (sync) + CLK_PER_BIT/2 + 9·CLK_PER_BIT + 1 cycles after the `rxd` falling edge, ±1 cycle depending on edge phase.
- Back-to-back frames:
  - Returning to IDLE at mid-stop leaves CLK_PER_BIT/2 cycles of margin.
  - Zero idle time between frames must be received without loss.
- Timing rules:
  - `rx_ready` and `ferr` are never high in the same cycle.
  - Each is exactly 1 cycle wide.
- No overrun handling: the consumer must accept a byte in the `rx_ready` cycle. No backpressure exists.
- Reset mid-frame: the partial frame is discarded with no pulse. Reception restarts at the next low level on `rxs`.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, stop) is the 2-of-3 majority of `rxs` at counter values mid−1, mid, mid+1, where mid=CLK_PER_BIT/2−1. The decision is registered at mid+1, so all subsequent timing shifts by +1 cycle, `rx_ready` latency included.
- Undefined: single sample at mid. No vote logic is instantiated.

Decomposition:
- Shared package (existing types package):
  - typedefs w8/r8.
  - Constant UART_CLK_PER_BIT_DEFAULT=868, shared with the UART sender.
  - Enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
- Sub-module `sync_2ff` (1-bit two-flop synchroniser, reset value parameterised to 1). It is reusable for other async inputs.
- The rest of the block stays flat.

Test Plan (CLK_PER_BIT=16):
- Send 0x99 after reset: exactly one `rx_ready` pulse, `rdata`=8'h99, `ferr` never high, `busy` low again ≤9 cycles after stop-bit centre.
- Send 0x00, 0xFF, 0xAA, 0x55 back-to-back, zero idle between frames: 4 `rx_ready` pulses in order with correct `rdata`; pulses spaced 160±1 cycles.
- Drive `rxd` low for 5 cycles, then high: no `rx_ready`, no `ferr`, state returns to IDLE; the next frame 0x3C is received correctly.
- Frame 0x12 with stop bit 0, then `rxd` held low 40 cycles: one `ferr` pulse, no `rx_ready`, `rdata` keeps its previous value; after `rxd` returns high, 0x34 is received.
- Assert `reset` for 1 cycle during data bit 4 of 0x77: no pulse for that frame; all outputs at reset values; a following 0x5A frame is received.
- With UART_RX_MAJORITY_EN: a 1-cycle inverted glitch at the centre of every bit of 0xC3 still yields `rdata`=8'hC3. Without the macro, the same stimulus yields a wrong byte (checks that the vote logic is active).
